// File: rtl/instr_fetch_if.sv
// Fetch-stage signal bundle: instruction-memory req/ack, decode valid/ready,
// and the jump decisions returning from the control unit.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] instr_pc;

    logic              cond_jump;
    logic              branch_taken;
    logic              uncond_jump;
    logic [ADDR_W-1:0] jump_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc,
        input  imem_ack, imem_rdata, instr_ready,
        input  cond_jump, branch_taken, uncond_jump, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc,
        output imem_ack, imem_rdata, instr_ready,
        output cond_jump, branch_taken, uncond_jump, jump_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// KGPminiRISC instruction fetch: PC register, req/ack memory fetch, single-entry
// valid/ready output to decode, and jump redirects that squash stale words.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DROP,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

    logic              redir;
    logic [ADDR_W-1:0] target;

    assign redir  = bus.uncond_jump | (bus.cond_jump & bus.branch_taken);
    assign target = bus.jump_target & ~ADDR_W'(3);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; all registers here are plain flops, so all are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            instr_q     <= '0;
            instr_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
        end
    end

    // NOTE: every combinational output gets a hold-value default first, so no
    // path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (redir) begin
                    // An ack coinciding with the redirect is simply discarded.
                    pc_d = target;
                    if (!bus.imem_ack) begin
                        drop_addr_d = pc_q;
                        state_d     = S_DROP;
                    end
                end else if (bus.imem_ack) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_HOLD;
                end
            end
            S_DROP: begin
                // Keep the stale request alive until memory answers it.
                if (redir) pc_d = target;
                if (bus.imem_ack) state_d = S_FETCH;
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (bus.instr_ready) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q == S_FETCH) || (state_q == S_DROP);
        bus.imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q;
        bus.instr_valid = (state_q == S_HOLD);
        bus.instr       = instr_q;
        bus.opcode      = instr_q[31:26];
        bus.instr_pc    = instr_pc_q;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the KGPminiRISC datapath, on the producing side of the opcode/jump interface of the control unit. It holds the program counter and fetches 32-bit words from instruction memory over a req/ack handshake. Each word goes to decode with its `opcode` field split out, under a valid/ready handshake. The control unit's `CondJump`/`UncondJump` decisions come back to this block as redirects that reload the PC and discard in-flight or held instructions.

## Interface
- `ADDR_W`, 32: PC and memory address width.
- `RESET_PC`, 0: PC value after reset. Must be 4-byte aligned.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req` output 1: fetch request. Held high until `imem_ack`.
- `imem_addr` output ADDR_W: byte address of the fetch. Stable while `imem_req` is high.
- `imem_ack` input 1: memory response strobe, one cycle. May assert in the same cycle as `imem_req`.
- `imem_rdata` input 32: instruction word. Valid only with `imem_ack`.
- `instr_valid` output 1: `instr`, `opcode` and `instr_pc` are valid.
- `instr_ready` input 1: decode accepts. A transfer occurs when `instr_valid & instr_ready`.
- `instr` output 32: fetched word.
- `opcode` output 6: `instr[31:26]`, feeds the control unit.
- `instr_pc` output ADDR_W: address the word was fetched from.
- `cond_jump` input 1: conditional-jump pulse from the execute stage.
- `branch_taken` input 1: condition result. Only meaningful with `cond_jump`.
- `uncond_jump` input 1: unconditional-jump pulse.
- `jump_target` input ADDR_W: redirect address. Bits [1:0] are ignored and treated as 00.

## Operation
- Redirect: `redir = uncond_jump | (cond_jump & branch_taken)`. It is sampled every cycle. A `cond_jump` with `branch_taken = 0` is a no-op.
- `pc` register: ADDR_W bits. Sequential increment is `pc + 4` modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0x0000_0000.
- FSM states:
  - IDLE: entered on reset. Moves unconditionally to FETCH on the next cycle.
  - FETCH: `imem_req = 1`, `imem_addr = pc`.
    - On `imem_ack` without `redir`: latch `instr <= imem_rdata` and `instr_pc <= pc`, then go to HOLD.
    - On `redir` without ack: `pc <= target`, go to DROP.
    - On `redir` with ack in the same cycle: discard the data, `pc <= target`, stay in FETCH.
  - DROP: `imem_req = 1` at the old `imem_addr`, held so the handshake is not violated.
    - On `imem_ack`: discard the data, go to FETCH at the new `pc`.
    - A further `redir` while in DROP only updates `pc`.
  - HOLD: `instr_valid = 1`.
    - On transfer: `pc <= pc + 4`, go to FETCH.
    - On `redir`: `pc <= target`, drop the held word with no transfer, go to FETCH. Redirect has priority over `instr_ready` in the same cycle.
- `instr`, `opcode` and `instr_pc` are stable while `instr_valid = 1` and not accepted.
- `instr_valid` is registered: high exactly in HOLD.
- The block does not decode instructions, and never presents more than one instruction at a time.

## Timing
- Reset values: `imem_req = 0`, `imem_addr = RESET_PC`, `instr_valid = 0`, `instr = 0`, `opcode = 0`, `instr_pc = 0`, `pc = RESET_PC`, state IDLE.
- `rst` overrides everything, including an outstanding `imem_req`. Memory must tolerate a request abandoned by reset.
- After `rst` falls at edge E0, `imem_req` rises in the cycle after E0, which is the IDLE to FETCH transition.
- Ack in cycle N gives `instr_valid = 1` in cycle N+1.
- Transfer in cycle M gives `imem_req = 1` for `pc + 4` in cycle M+1.
- With zero-wait memory and `instr_ready` tied high, peak throughput is one instruction per 2 cycles.
- Redirect in cycle R, not in DROP, with ack same cycle or HOLD: `imem_req` to `target` in cycle R+1. No instruction from before R is presented after R.
- Redirect in cycle R while waiting with no ack: the target request is issued the cycle after the stale ack arrives.

## Test plan
- Reset release with zero-wait memory and `instr_ready = 1`, memory word at address a = 0x0400_0000 + a: first request is to 0x0, then 0x4, 0x8. `instr_valid` is high every other cycle. `opcode = 6'b000001` and `instr_pc` matches each address.
- Backpressure: hold `instr_ready = 0` for 5 cycles in HOLD. `instr_valid`, `instr` and `instr_pc` stay constant, and no `imem_req` occurs. Raising `instr_ready` transfers once, then the request goes to `pc + 4`.
- `uncond_jump` with target 0x100 while in HOLD, with `instr_ready = 1` the same cycle: no transfer. The next cycle requests 0x100 and the next `instr_pc` is 0x100.
- `cond_jump` with `branch_taken = 0` leaves the sequential path unchanged. With `branch_taken = 1` and target 0x203, the next request is to 0x200.
- Redirect to 0x40 during a 3-wait-state fetch of 0x10: `imem_addr` holds 0x10 until ack, the 0x10 data is never presented, and the next request is 0x40.
- Wrap-around and reset: with `RESET_PC = 0xFFFF_FFFC`, the second fetch is to 0x0. Asserting `rst` mid-FETCH drops `imem_req` and `instr_valid` at the next edge and restarts at `RESET_PC`.
